// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// The top index of the address space is the PC slot and has no storage behind it.
package regfile_pkg;

  localparam int REGFILE_WIDTH = 32;
  localparam int REGFILE_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  function automatic logic is_pc_idx(input logic [31:0] addr, input int unsigned depth);
    return (addr == 32'(depth - 32'd1));
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write ports, read ports, PC input, debug peek and clear handshake.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = REGFILE_WIDTH,
  parameter int DEPTH = REGFILE_DEPTH,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(DEPTH)
);

  logic [NWR-1:0]            we;
  logic [NWR-1:0][AW-1:0]    wa;
  logic [NWR-1:0][WIDTH-1:0] wd;
  logic [NRD-1:0][AW-1:0]    ra;
  logic [NRD-1:0][WIDTH-1:0] rd;
  logic [WIDTH-1:0]          pc_in;
  logic [AW-1:0]             peek_addr;
  logic [WIDTH-1:0]          peek_data;
  logic                      clear_req;
  logic                      clear_busy;
  logic                      clear_done;

  modport master (
    output we, wa, wd, ra, pc_in, peek_addr, clear_req,
    input  rd, peek_data, clear_busy, clear_done
  );

  modport slave (
    input  we, wa, wd, ra, pc_in, peek_addr, clear_req,
    output rd, peek_data, clear_busy, clear_done
  );

endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port: PC slot select, priority write bypass, storage read.
// With bypass_en low it is a plain storage/PC read (used for the debug peek path).
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH = REGFILE_WIDTH,
  parameter int DEPTH = REGFILE_DEPTH,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic [AW-1:0]                ra,
  input  logic [WIDTH-1:0]             pc_in,
  input  logic                         bypass_en,
  input  logic [NWR-1:0]               we,
  input  logic [NWR-1:0][AW-1:0]       wa,
  input  logic [NWR-1:0][WIDTH-1:0]    wd,
  input  logic [DEPTH-2:0][WIDTH-1:0]  mem,
  output logic [WIDTH-1:0]             rd
);

  logic             hit_s;
  logic [WIDTH-1:0] byp_data_s;
  logic [WIDTH-1:0] mem_data_s;

  // Bypass search: later ports overwrite earlier matches, so the highest port wins.
  always_comb begin
    hit_s      = 1'b0;
    byp_data_s = '0;
    for (int i = 0; i < NWR; i++) begin
      hit_s      = hit_s | (bypass_en & we[i] & (wa[i] == ra));
      byp_data_s = (bypass_en && we[i] && (wa[i] == ra)) ? wd[i] : byp_data_s;
    end
  end

  // Storage read, guarded so the PC index never addresses the array.
  always_comb begin
    mem_data_s = '0;
    if (32'(ra) < 32'(DEPTH - 1)) begin
      mem_data_s = mem[ra];
    end else begin
      mem_data_s = '0;
    end
  end

  // Output select: PC slot first, then bypass, then storage.
  always_comb begin
    rd = mem_data_s;
    if (is_pc_idx(32'(ra), DEPTH)) begin
      rd = pc_in;
    end else if (hit_s) begin
      rd = byp_data_s;
    end else begin
      rd = mem_data_s;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file for the decode stage with PC slot, debug peek
// and a sequential clear engine (IDLE -> CLEAR -> DONE).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH = REGFILE_WIDTH,
  parameter int DEPTH = REGFILE_DEPTH,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_mp_if.slave  bus
);

  logic [DEPTH-2:0][WIDTH-1:0] mem_r;
  clr_state_t                  state_r;
  clr_state_t                  state_s;
  logic [AW-1:0]               cnt_r;
  logic [AW-1:0]               cnt_s;
  logic                        busy_r;
  logic                        busy_s;
  logic                        done_r;
  logic                        done_s;
  logic                        idle_s;
  logic [NRD-1:0][WIDTH-1:0]   rd_s;
  logic [WIDTH-1:0]            peek_s;

  assign idle_s = (state_r == IDLE);

  // Clear FSM state, counter and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic; the counter stops at DEPTH-2 so it never wraps.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.clear_req) begin
          state_s = CLEAR;
          cnt_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        if (cnt_r == AW'(DEPTH - 2)) begin
          state_s = DONE;
        end else begin
          cnt_s = cnt_r + AW'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
  end

  // Storage: clear engine owns the array while busy, otherwise ascending port order gives top-port priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_r <= '0;
    end else if (state_r == CLEAR) begin
      mem_r[cnt_r] <= '0;
    end else if (state_r == IDLE) begin
      for (int i = 0; i < NWR; i++) begin
        if (bus.we[i] && !is_pc_idx(32'(bus.wa[i]), DEPTH)) begin
          mem_r[bus.wa[i]] <= bus.wd[i];
        end
      end
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    regfile_rdport #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .NWR   (NWR)
    ) u_rdport (
      .ra        (bus.ra[j]),
      .pc_in     (bus.pc_in),
      .bypass_en (idle_s),
      .we        (bus.we),
      .wa        (bus.wa),
      .wd        (bus.wd),
      .mem       (mem_r),
      .rd        (rd_s[j])
    );
  end

  regfile_rdport #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .NWR   (NWR)
  ) u_peek (
    .ra        (bus.peek_addr),
    .pc_in     (bus.pc_in),
    .bypass_en (1'b0),
    .we        (bus.we),
    .wa        (bus.wa),
    .wd        (bus.wd),
    .mem       (mem_r),
    .rd        (peek_s)
  );

  assign bus.rd         = rd_s;
  assign bus.peek_data  = peek_s;
  assign bus.clear_busy = busy_r;
  assign bus.clear_done = done_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  regfile_mp_if #(.WIDTH(W), .DEPTH(D), .NRD(NR), .NWR(NW)) bus ();

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NRD(NR), .NWR(NW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: stored entries plus clear age (0 = idle, 1..15 clearing, 16 = done cycle).
  logic [W-1:0] mdl_mem [0:D-2];
  int           age;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
    logic [W-1:0] v;
    if (a == AW'(D - 1)) return bus.pc_in;
    v = mdl_mem[a];
    if (byp && age == 0) begin
      for (int i = 0; i < NW; i++)
        if (bus.we[i] && bus.wa[i] == a) v = bus.wd[i];
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < D - 1; a++) mdl_mem[a] = '0;
    age = 0;
  endtask

  task automatic model_edge();
    if (age == 0) begin
      for (int i = 0; i < NW; i++)
        if (bus.we[i] && bus.wa[i] != AW'(D - 1)) mdl_mem[bus.wa[i]] = bus.wd[i];
      if (bus.clear_req) age = 1;
    end else begin
      if (age <= D - 1) mdl_mem[age - 1] = '0;
      age = (age == D) ? 0 : age + 1;
    end
  endtask

  task automatic check_outputs();
    check_eq("rd0", bus.rd[0], exp_read(bus.ra[0], 1'b1));
    check_eq("rd1", bus.rd[1], exp_read(bus.ra[1], 1'b1));
    check_eq("peek", bus.peek_data, exp_read(bus.peek_addr, 1'b0));
    check_eq("busy", 32'(bus.clear_busy), 32'(age != 0));
    check_eq("done", 32'(bus.clear_done), 32'(age == D));
  endtask

  // Called just after an edge with inputs already set: check mid-cycle, then clock and advance the model.
  task automatic cycle();
    #4;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  int busy_cnt;
  int done_cnt;
  int done_at;
  int done_q[$];

  initial begin
    reset_n       = 1'b0;
    bus.we        = '0;
    bus.wa        = '0;
    bus.wd        = '0;
    bus.ra        = '0;
    bus.pc_in     = '0;
    bus.peek_addr = '0;
    bus.clear_req = 1'b0;
    model_reset();
    #2;
    check_eq("rst_busy", 32'(bus.clear_busy), 32'h0);
    check_eq("rst_done", 32'(bus.clear_done), 32'h0);
    for (int a = 0; a < D - 1; a++) begin
      bus.peek_addr = 4'(a);
      bus.ra[0]     = 4'(a);
      #1;
      check_eq("rst_peek", bus.peek_data, 32'h0);
      check_eq("rst_rd", bus.rd[0], 32'h0);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic write/read with bypass, then storage
    bus.we = 2'b01; bus.wa[0] = 4'd3; bus.wd[0] = 32'hDEADBEEF;
    bus.ra[0] = 4'd3; bus.peek_addr = 4'd3;
    #1;
    check_eq("basic_byp", bus.rd[0], 32'hDEADBEEF);
    check_eq("basic_peek_pre", bus.peek_data, 32'h0);
    cycle();
    bus.we = '0;
    #1;
    check_eq("basic_stored", bus.rd[0], 32'hDEADBEEF);
    check_eq("basic_peek_post", bus.peek_data, 32'hDEADBEEF);
    cycle();

    // Collision: port 1 wins
    bus.we = 2'b11; bus.wa[0] = 4'd5; bus.wa[1] = 4'd5;
    bus.wd[0] = 32'h11; bus.wd[1] = 32'h22; bus.ra[0] = 4'd5; bus.peek_addr = 4'd5;
    #1;
    check_eq("coll_byp", bus.rd[0], 32'h22);
    cycle();
    bus.we = '0;
    #1;
    check_eq("coll_stored", bus.peek_data, 32'h22);
    cycle();

    // PC slot
    bus.pc_in = 32'h00000100; bus.ra[1] = 4'd15; bus.peek_addr = 4'd15;
    #1;
    check_eq("pc_rd_pre", bus.rd[1], 32'h00000100);
    check_eq("pc_peek", bus.peek_data, 32'h00000100);
    bus.we = 2'b01; bus.wa[0] = 4'd15; bus.wd[0] = 32'hFFFFFFFF;
    #1;
    check_eq("pc_rd_wr", bus.rd[1], 32'h00000100);
    cycle();
    bus.we = '0;
    #1;
    check_eq("pc_rd_post", bus.rd[1], 32'h00000100);
    cycle();

    // Clear sequence with a dropped write during busy
    for (int i = 0; i < D - 1; i++) begin
      bus.we = 2'b01; bus.wa[0] = 4'(i); bus.wd[0] = 32'(i + 1);
      bus.ra[0] = 4'(i); bus.ra[1] = 4'($urandom);
      cycle();
    end
    bus.we = '0; bus.clear_req = 1'b1;
    cycle();
    bus.clear_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.clear_busy) busy_cnt++;
      if (bus.clear_done) begin done_cnt++; done_at = k; end
      if (k == 3) begin
        bus.we = 2'b10; bus.wa[1] = 4'd2; bus.wd[1] = 32'hAAAA5555;
      end else begin
        bus.we = '0;
      end
      bus.ra[0] = 4'($urandom); bus.ra[1] = 4'($urandom); bus.peek_addr = 4'($urandom);
      cycle();
    end
    bus.we = '0;
    check_eq("clr_busy_cycles", 32'(busy_cnt), 32'd16);
    check_eq("clr_done_count", 32'(done_cnt), 32'd1);
    check_eq("clr_done_at", 32'(done_at), 32'd16);
    for (int a = 0; a < D - 1; a++) begin
      bus.peek_addr = 4'(a); bus.ra[0] = 4'(a);
      #1;
      check_eq("clr_zero", bus.peek_data, 32'h0);
      cycle();
    end

    // Reset in the middle of a clear
    for (int i = 0; i < 6; i++) begin
      bus.we = 2'($urandom); bus.wa[0] = 4'($urandom); bus.wa[1] = 4'($urandom);
      bus.wd[0] = $urandom; bus.wd[1] = $urandom;
      cycle();
    end
    bus.we = '0; bus.clear_req = 1'b1;
    cycle();
    bus.clear_req = 1'b0;
    for (int k = 1; k <= 6; k++) cycle();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("rstmid_busy", 32'(bus.clear_busy), 32'h0);
    check_eq("rstmid_done", 32'(bus.clear_done), 32'h0);
    for (int a = 0; a < D - 1; a++) begin
      bus.ra[0] = 4'(a); bus.ra[1] = 4'(D - 2 - a);
      #1;
      check_eq("rstmid_rd0", bus.rd[0], 32'h0);
      check_eq("rstmid_rd1", bus.rd[1], 32'h0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) cycle();

    // Held clear_req: back-to-back clears
    bus.clear_req = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      bus.ra[0] = 4'($urandom); bus.ra[1] = 4'($urandom);
      cycle();
      if (bus.clear_done) done_q.push_back(k);
    end
    bus.clear_req = 1'b0;
    check_eq("held_done_n", 32'(done_q.size() >= 2), 32'd1);
    check_eq("held_done1", (done_q.size() > 0) ? 32'(done_q[0]) : 32'hFFFFFFFF, 32'd16);
    check_eq("held_done2", (done_q.size() > 1) ? 32'(done_q[1]) : 32'hFFFFFFFF, 32'd33);
    for (int k = 0; k < 40 && age != 0; k++) cycle();
    check_eq("held_drain", 32'(bus.clear_busy), 32'h0);

    // Randomised traffic with occasional clears
    for (int k = 0; k < 400; k++) begin
      bus.we        = 2'($urandom);
      bus.wa[0]     = 4'($urandom);
      bus.wa[1]     = ($urandom_range(0, 3) == 0) ? bus.wa[0] : 4'($urandom);
      bus.wd[0]     = $urandom;
      bus.wd[1]     = $urandom;
      bus.ra[0]     = ($urandom_range(0, 2) == 0) ? bus.wa[1] : 4'($urandom);
      bus.ra[1]     = 4'($urandom);
      bus.peek_addr = 4'($urandom);
      bus.pc_in     = $urandom;
      bus.clear_req = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port successor to the 16x32 processor register file; sits in the decode stage of the pipelined core.
- Provides NRD combinational read ports, NWR synchronous write ports with fixed priority, and write-to-read bypass. The top index (PC slot) reads the externally supplied PC value.
- Adds a debug peek port and a runtime clear engine that sequentially zeroes the array, with a busy/done handshake.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 16, number of architectural registers, including the PC slot at index DEPTH-1; power of two, >= 4.
- NRD, 2, number of read ports, >= 1.
- NWR, 2, number of write ports, >= 1.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- we  in  NWR  per-port write enable.
- wa  in  NWR x AW  per-port write address.
- wd  in  NWR x WIDTH  per-port write data.
- ra  in  NRD x AW  per-port read address.
- rd  out  NRD x WIDTH  per-port read data (combinational).
- pc_in  in  WIDTH  value returned for reads of index DEPTH-1.
- peek_addr  in  AW  debug read address (board switches).
- peek_data  out  WIDTH  debug read data (combinational, no bypass).
- clear_req  in  1  single-cycle or level request to zero the array.
- clear_busy  out  1  high while the clear engine runs.
- clear_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, named reset_n.
- Reset state: all DEPTH-1 storage entries = 0, FSM = IDLE, clear_busy = 0, clear_done = 0, clear counter = 0.
- Storage: DEPTH-1 entries; no storage for index DEPTH-1.
- Writes:
  - Take effect on the rising edge when we[i] = 1.
  - A write to wa = DEPTH-1 is silently dropped.
  - Same-address collision: the highest-numbered port wins.
- Reads:
  - rd[j] = pc_in if ra[j] = DEPTH-1.
  - Else, in IDLE, if any we[i] && wa[i] == ra[j]: return wd of the highest such i (bypass).
  - Else return the stored entry.
  - Read latency is 0 cycles; write-to-read latency is 0 via bypass, 1 cycle via storage.
- peek_data: pc_in if peek_addr = DEPTH-1, else the stored entry; never bypassed.
- FSM states IDLE, CLEAR, DONE:
  - IDLE: clear_req = 1 -> CLEAR, counter <= 0.
  - CLEAR: each cycle entry[counter] <= 0 and counter++. When counter = DEPTH-2, zero that entry and go to DONE. The clear takes exactly DEPTH-1 cycles.
  - DONE: clear_done = 1 for this single cycle -> IDLE.
- clear_busy = 1 in CLEAR and DONE.
- While clear_busy = 1:
  - All external writes are dropped and bypass is disabled.
  - Reads return the stored contents, so a partially cleared array is visible.
  - clear_req is ignored.
- clear_req held high through DONE starts a new clear on the cycle after returning to IDLE (level-sensitive in IDLE only).
- A write and clear_req asserted in the same IDLE cycle: the write commits, then the clear overwrites it.
- reset_n asserted mid-clear: immediate return to the reset state; no clear_done pulse.
- Counter wrap: the counter never exceeds DEPTH-2; no wrap-around.
- Widths: no arithmetic on data; the counter is AW bits wide.

Decomposition:
- Package regfile_pkg holds:
  - enum clr_state_t {IDLE, CLEAR, DONE};
  - localparam defaults REGFILE_WIDTH = 32 and REGFILE_DEPTH = 16;
  - function is_pc_idx(addr, depth).
- One natural sub-module, regfile_rdport: the per-read-port mux (PC select, priority bypass over NWR ports, storage read). It is instantiated NRD times via generate; peek reuses it with bypass disabled.

Test Plan:
- Basic write/read:
  - Stimulus: we[0]=1, wa[0]=3, wd[0]=0xDEADBEEF for one cycle, then ra[0]=3.
  - Required: rd[0]=0xDEADBEEF in the same cycle (bypass) and the next (stored); peek_addr=3 gives 0xDEADBEEF only after the edge.
- Write collision:
  - Stimulus: we=2'b11, wa[0]=wa[1]=5, wd[0]=0x11, wd[1]=0x22.
  - Required: rd=0x22 while the write is in flight and the stored value is 0x22.
- PC slot:
  - Stimulus: pc_in=0x00000100; write 0xFFFFFFFF to index 15; ra[1]=15.
  - Required: rd[1]=0x00000100 before and after the write; peek_addr=15 gives 0x00000100.
- Clear sequence:
  - Stimulus: registers 0..14 = i+1, then a one-cycle clear_req.
  - Required: clear_busy high for 16 cycles; clear_done pulses once, in cycle 16; entries read 0 afterwards; a write during busy is dropped.
- Reset mid-clear:
  - Stimulus: assert reset_n=0 asynchronously at clear cycle 7.
  - Required: clear_busy=0 and all rd=0 (except PC) immediately; no clear_done pulse.
- Held clear_req:
  - Stimulus: clear_req held high for 40 cycles.
  - Required: two complete clears with clear_done pulses at cycles 16 and 33.
